// File: rtl/fetch_unit_bp.sv
// Instruction fetch stage with a small fetch queue, RV32I predecode and a
// bimodal 2-bit branch predictor trained by the ROB at commit.
module fetch_unit_bp #(
    parameter int          PHT_IDX_W = 4,
    parameter int          IQ_DEPTH  = 4,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        hit,
    input  logic [31:0] ins,
    output logic [31:0] addr_to_icache,
    output logic        issue_en,
    output logic [31:0] issue_ins,
    output logic [31:0] issue_pc,
    output logic        pred_taken,
    output logic [31:0] pred_pc,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    input  logic        rs_next_full,
    input  logic        rob_next_full,
    input  logic        lsb_next_full,
    input  logic        clear,
    input  logic [31:0] new_pc,
    input  logic        bp_upd_en,
    input  logic [31:0] bp_upd_pc,
    input  logic        bp_upd_taken
);

    localparam int PHT_N = 2 ** PHT_IDX_W;
    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] next_pc;
    } entry_t;

    function automatic logic [31:0] decode_imm(input logic [31:0] w);
        case (opcode_e'(w[6:0]))
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
                decode_imm = {{20{w[31]}}, w[31:20]};
            OP_STORE:  decode_imm = {{20{w[31]}}, w[31:25], w[11:7]};
            OP_BRANCH: decode_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                decode_imm = {w[31:12], 12'b0};
            OP_JAL:    decode_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:   decode_imm = 32'h0;
        endcase
    endfunction

    entry_t               queue [IQ_DEPTH];
    logic [1:0]           pht   [PHT_N];
    logic [PTR_W-1:0]     head, tail;
    logic [CNT_W-1:0]     count;
    logic [31:0]          pc;

    logic [PHT_IDX_W-1:0] lookup_idx, upd_idx;
    logic [31:0]          fetch_imm, fetch_next;
    logic                 fetch_taken;
    logic                 push, pop;
    entry_t               head_e;
    logic                 unused_upd_bits;

    assign addr_to_icache  = pc;
    assign lookup_idx      = pc[PHT_IDX_W+1:2];
    assign upd_idx         = bp_upd_pc[PHT_IDX_W+1:2];
    assign unused_upd_bits = ^{bp_upd_pc[31:PHT_IDX_W+2], bp_upd_pc[1:0]};
    assign fetch_imm       = decode_imm(ins);
    assign head_e          = queue[head];

    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign pop  = rdy && !clear && (count != '0) &&
                  !(rs_next_full || rob_next_full || lsb_next_full);
    assign push = rdy && !clear && hit && ((count != CNT_W'(IQ_DEPTH)) || pop);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fetch_taken = 1'b0;
        fetch_next  = pc + 32'd4;
        case (opcode_e'(ins[6:0]))
            OP_JAL: begin
                fetch_taken = 1'b1;
                fetch_next  = pc + fetch_imm;
            end
            OP_BRANCH: begin
                if (pht[lookup_idx][1]) begin
                    fetch_taken = 1'b1;
                    fetch_next  = pc + fetch_imm;
                end
            end
            default: ;
        endcase
    end

    // NOTE: queue payload is left unreset; count alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            queue[tail] <= '{ins: ins, pc: pc, taken: fetch_taken, next_pc: fetch_next};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so the PHT
    // lookup above always sees the pre-update counter value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= RESET_PC;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            issue_en   <= 1'b0;
            issue_ins  <= '0;
            issue_pc   <= '0;
            pred_taken <= 1'b0;
            pred_pc    <= '0;
            rs1        <= '0;
            rs2        <= '0;
            imm        <= '0;
            // NOTE: the PHT is small and must start weakly not-taken, so it is reset.
            for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
        end else if (rdy) begin
            if (bp_upd_en) begin
                if (bp_upd_taken && pht[upd_idx] != 2'b11)
                    pht[upd_idx] <= pht[upd_idx] + 2'b01;
                else if (!bp_upd_taken && pht[upd_idx] != 2'b00)
                    pht[upd_idx] <= pht[upd_idx] - 2'b01;
            end

            if (clear) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                pc       <= new_pc;
                issue_en <= 1'b0;
            end else begin
                if (push) begin
                    tail <= tail + PTR_W'(1);
                    pc   <= fetch_next;
                end
                if (pop) begin
                    head       <= head + PTR_W'(1);
                    issue_en   <= 1'b1;
                    issue_ins  <= head_e.ins;
                    issue_pc   <= head_e.pc;
                    pred_taken <= head_e.taken;
                    pred_pc    <= head_e.next_pc;
                    rs1        <= head_e.ins[19:15];
                    rs2        <= head_e.ins[24:20];
                    imm        <= decode_imm(head_e.ins);
                end else begin
                    issue_en <= 1'b0;
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end else begin
            issue_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit_bp.sv
// Directed bench for fetch_unit_bp: reset, predecode, prediction/training,
// backpressure, flush, async reset and rdy stall.
module tb_fetch_unit_bp;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        hit;
    logic [31:0] ins;
    logic [31:0] addr_to_icache;
    logic        issue_en;
    logic [31:0] issue_ins;
    logic [31:0] issue_pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic [4:0]  rs1, rs2;
    logic [31:0] imm;
    logic        rs_next_full, rob_next_full, lsb_next_full;
    logic        clear;
    logic [31:0] new_pc;
    logic        bp_upd_en;
    logic [31:0] bp_upd_pc;
    logic        bp_upd_taken;

    int passed = 0;
    int total  = 0;

    localparam logic [31:0] ADDI_M1 = 32'hFFF1_0093;  // addi x1, x2, -1
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] JAL16   = 32'h0100_006F;  // jal x0, +16
    localparam logic [31:0] BEQ32   = 32'h0200_0063;  // beq x0, x0, +32

    fetch_unit_bp dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .hit            (hit),
        .ins            (ins),
        .addr_to_icache (addr_to_icache),
        .issue_en       (issue_en),
        .issue_ins      (issue_ins),
        .issue_pc       (issue_pc),
        .pred_taken     (pred_taken),
        .pred_pc        (pred_pc),
        .rs1            (rs1),
        .rs2            (rs2),
        .imm            (imm),
        .rs_next_full   (rs_next_full),
        .rob_next_full  (rob_next_full),
        .lsb_next_full  (lsb_next_full),
        .clear          (clear),
        .new_pc         (new_pc),
        .bp_upd_en      (bp_upd_en),
        .bp_upd_pc      (bp_upd_pc),
        .bp_upd_taken   (bp_upd_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_addi(input logic [31:0] a);
        mk_addi = NOP | {a[11:0], 20'h0};
    endfunction

    task automatic redirect(input logic [31:0] target);
        clear  = 1'b1;
        new_pc = target;
        tick();
        clear  = 1'b0;
    endtask

    task automatic train(input logic taken, input int n);
        bp_upd_en    = 1'b1;
        bp_upd_pc    = 32'h40;
        bp_upd_taken = taken;
        for (int i = 0; i < n; i++) tick();
        bp_upd_en    = 1'b0;
    endtask

    // Fetch the BEQ at 0x40 and check the predicted next PC and the issue.
    task automatic fetch_beq(input string tag, input logic exp_taken);
        logic [31:0] exp_next;
        exp_next = exp_taken ? 32'h60 : 32'h44;
        redirect(32'h40);
        hit = 1'b1;
        ins = BEQ32;
        tick();
        hit = 1'b0;
        check({tag, "_pc"}, addr_to_icache, exp_next);
        tick();
        check({tag, "_taken"}, {31'b0, pred_taken}, {31'b0, exp_taken});
        check({tag, "_pred_pc"}, pred_pc, exp_next);
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; hit = 1'b0; ins = '0;
        rs_next_full = 1'b0; rob_next_full = 1'b0; lsb_next_full = 1'b0;
        clear = 1'b0; new_pc = '0;
        bp_upd_en = 1'b0; bp_upd_pc = '0; bp_upd_taken = 1'b0;

        // 1: reset state, then ADDI through the queue
        #2;
        check("rst_addr", addr_to_icache, 32'h0);
        check("rst_issue_en", {31'b0, issue_en}, 32'h0);
        check("rst_imm", imm, 32'h0);
        #1 rst = 1'b1;
        hit = 1'b1;
        ins = ADDI_M1;
        tick();
        hit = 1'b0;
        check("addi_pc", addr_to_icache, 32'h4);
        tick();
        check("addi_issue_en", {31'b0, issue_en}, 32'h1);
        check("addi_issue_pc", issue_pc, 32'h0);
        check("addi_ins", issue_ins, ADDI_M1);
        check("addi_rs1", {27'b0, rs1}, 32'd2);
        check("addi_rs2", {27'b0, rs2}, 32'd31);
        check("addi_imm", imm, 32'hFFFF_FFFF);
        check("addi_pred_pc", pred_pc, 32'h4);

        // 2: JAL predicted taken
        hit = 1'b1;
        ins = NOP;
        tick();
        ins = JAL16;
        tick();
        hit = 1'b0;
        check("jal_fetch_pc", addr_to_icache, 32'h18);
        check("nop_issue_pc", issue_pc, 32'h4);
        tick();
        check("jal_issue_pc", issue_pc, 32'h8);
        check("jal_taken", {31'b0, pred_taken}, 32'h1);
        check("jal_pred_pc", pred_pc, 32'h18);
        check("jal_imm", imm, 32'd16);
        tick();
        check("idle_issue_en", {31'b0, issue_en}, 32'h0);

        // 3: bimodal predictor training and saturation
        fetch_beq("beq_init", 1'b0);
        check("beq_imm", imm, 32'd32);
        train(1'b1, 2);            // 01 -> 11
        fetch_beq("beq_trained", 1'b1);
        train(1'b1, 1);            // stays 11
        train(1'b0, 2);            // 11 -> 01
        fetch_beq("beq_sat_hi", 1'b0);
        train(1'b0, 3);            // 01 -> 00, clamps
        train(1'b1, 1);            // 00 -> 01
        fetch_beq("beq_sat_lo", 1'b0);

        // 4: backpressure fills the queue, then in-order drain
        redirect(32'h200);
        rob_next_full = 1'b1;
        hit = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ins = mk_addi(addr_to_icache);
            tick();
            check("bp_no_issue", {31'b0, issue_en}, 32'h0);
        end
        check("bp_pc_frozen", addr_to_icache, 32'h210);
        rob_next_full = 1'b0;
        ins = mk_addi(addr_to_icache);
        tick();
        hit = 1'b0;
        check("full_pushpop_pc", addr_to_icache, 32'h214);
        check("full_pushpop_issue", issue_pc, 32'h200);
        check("full_pushpop_imm", imm, 32'h200);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("drain_en", {31'b0, issue_en}, 32'h1);
            check("drain_pc", issue_pc, 32'h200 + 32'(4 * k));
            check("drain_imm", imm, 32'h200 + 32'(4 * k));
        end
        tick();
        check("drain_done", {31'b0, issue_en}, 32'h0);

        // 5: clear with three queued entries and a live hit
        rob_next_full = 1'b1;
        hit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ins = mk_addi(addr_to_icache);
            tick();
        end
        check("pre_clear_pc", addr_to_icache, 32'h220);
        rob_next_full = 1'b0;
        clear  = 1'b1;
        new_pc = 32'h100;
        ins    = mk_addi(addr_to_icache);
        tick();
        clear = 1'b0;
        hit   = 1'b0;
        check("clear_pc", addr_to_icache, 32'h100);
        check("clear_issue_en", {31'b0, issue_en}, 32'h0);
        tick();
        check("clear_empty1", {31'b0, issue_en}, 32'h0);
        tick();
        check("clear_empty2", {31'b0, issue_en}, 32'h0);
        hit = 1'b1;
        ins = mk_addi(32'h100);
        tick();
        hit = 1'b0;
        tick();
        check("post_clear_issue", issue_pc, 32'h100);

        // 6: asynchronous reset mid-run, then rdy stall
        hit = 1'b1;
        ins = mk_addi(addr_to_icache);
        tick();
        hit = 1'b0;
        tick();
        check("pre_rst_issue_en", {31'b0, issue_en}, 32'h1);
        #3 rst = 1'b0;
        #1;
        check("async_issue_en", {31'b0, issue_en}, 32'h0);
        check("async_issue_pc", issue_pc, 32'h0);
        check("async_addr", addr_to_icache, 32'h0);
        check("async_imm", imm, 32'h0);
        #1 rst = 1'b1;
        hit = 1'b1;
        ins = NOP;
        tick();
        check("rdy_pre_pc", addr_to_icache, 32'h4);
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_pc", addr_to_icache, 32'h4);
            check("stall_issue_en", {31'b0, issue_en}, 32'h0);
        end
        rdy = 1'b1;
        hit = 1'b0;
        tick();
        check("resume_issue_en", {31'b0, issue_en}, 32'h1);
        check("resume_issue_pc", issue_pc, 32'h0);
        tick();
        check("resume_single", {31'b0, issue_en}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
